// File: rtl/ov5640_cfg_pkg.sv
// Shared definitions for the OV5640 register-table configuration sequencer:
// state encoding, table-entry field positions and default timing constants.
package ov5640_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_REQ,
    S_GAP,
    S_DELAY,
    S_DONE,
    S_ERR
  } cfg_state_e;

  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int IDX_W    = 9;

  localparam int DEF_PWRUP_CYC   = 500000;
  localparam int DEF_RST_DLY_CYC = 125000;
  localparam int DEF_GAP_CYC     = 256;
  localparam int DEF_RST_INDEX   = 1;
  localparam int DEF_MAX_RETRY   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Free-running wait counter shared by the power-up, gap and reset-delay
// states; cleared on state entry, flags when it reaches the terminal value.
module cfg_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/ov5640_cfg_seq.sv
// Walks the OV5640 register table, issuing one SCCB write per entry with
// power-up wait, post-reset delay, inter-write gap and bounded NACK retry.
module ov5640_cfg_seq
  import ov5640_cfg_pkg::*;
#(
  parameter int PWRUP_CYC   = DEF_PWRUP_CYC,
  parameter int RST_DLY_CYC = DEF_RST_DLY_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int RST_INDEX   = DEF_RST_INDEX,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  output logic [IDX_W-1:0] reg_index_o,
  input  logic [31:0]      reg_data_i,
  input  logic [IDX_W-1:0] reg_size_i,
  output logic             wr_req_o,
  output logic [15:0]      wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic             wr_ack_i,
  input  logic             wr_nack_i,
  output logic             cfg_busy_o,
  output logic             cfg_done_o,
  output logic             cfg_err_o
);

  localparam int CNT_MAX = max3(PWRUP_CYC, RST_DLY_CYC, GAP_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  cfg_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, size_q, size_d, idx_nxt;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             resend_q, resend_d;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic             unused_hi;

  assign unused_hi = ^reg_data_i[31:24];
  assign idx_nxt   = idx_q + 1'b1;

  cfg_delay_cnt #(.W(CNT_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state_d != state_q),
    .term_i (term),
    .tc_o   (tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    retry_d  = retry_q;
    resend_d = resend_q;
    term     = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (cfg_start_i) begin
          state_d = S_PWRUP;
          idx_d   = '0;
          size_d  = reg_size_i;
        end
      end
      S_PWRUP: begin
        term = CNT_W'(PWRUP_CYC - 1);
        if (tc) state_d = (size_q == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        addr_d   = reg_data_i[ADDR_MSB:ADDR_LSB];
        data_d   = reg_data_i[DATA_MSB:0];
        retry_d  = '0;
        resend_d = 1'b0;
        state_d  = S_REQ;
      end
      S_REQ: begin
        // A simultaneous ack+nack is treated as a failed write.
        if (wr_nack_i) begin
          if (retry_q == RTY_W'(MAX_RETRY)) begin
            state_d = S_ERR;
          end else begin
            retry_d  = retry_q + 1'b1;
            resend_d = 1'b1;
            state_d  = S_GAP;
          end
        end else if (wr_ack_i) begin
          resend_d = 1'b0;
          state_d  = (idx_q == IDX_W'(RST_INDEX)) ? S_DELAY : S_GAP;
        end
      end
      S_GAP, S_DELAY: begin
        term = (state_q == S_GAP) ? CNT_W'(GAP_CYC - 1) : CNT_W'(RST_DLY_CYC - 1);
        if (tc) begin
          if (resend_q) begin
            state_d = S_REQ;
          end else begin
            idx_d   = idx_nxt;
            state_d = (idx_nxt == size_q) ? S_DONE : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      retry_q  <= '0;
      resend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      resend_q <= resend_d;
    end
  end

  assign reg_index_o = idx_q;
  assign wr_req_o    = (state_q == S_REQ);
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign cfg_done_o  = (state_q == S_DONE);
  assign cfg_err_o   = (state_q == S_ERR);
  assign cfg_busy_o  = !(state_q inside {S_IDLE, S_DONE, S_ERR});

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Scoreboard bench for ov5640_cfg_seq: expected writes (index, addr, data and
// spacing in clocks) are queued at start and matched against each new request.
module tb_ov5640_cfg_seq;

  localparam int PW = 10, DLY = 50, GAP = 4, RSTI = 1, MAXR = 3;

  logic        clk = 1'b0;
  logic        rst, start, req, ack, nack, busy, done, err;
  logic [8:0]  idx, size;
  logic [31:0] rdata;
  logic [15:0] waddr;
  logic [7:0]  wdata;

  always #5 clk = ~clk;

  ov5640_cfg_seq #(
    .PWRUP_CYC(PW), .RST_DLY_CYC(DLY), .GAP_CYC(GAP), .RST_INDEX(RSTI), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start), .reg_index_o(idx), .reg_data_i(rdata),
    .reg_size_i(size), .wr_req_o(req), .wr_addr_o(waddr), .wr_data_o(wdata),
    .wr_ack_i(ack), .wr_nack_i(nack), .cfg_busy_o(busy), .cfg_done_o(done), .cfg_err_o(err)
  );

  typedef struct {
    int          idx;
    logic [15:0] addr;
    logic [7:0]  data;
    int          dly;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, ref_cyc = 0, rsp_age = 0;
  int   nack_left[512];
  int   both_left[512];
  logic exp_err;
  int   exp_idx;
  logic mon_prev = 1'b0;

  function automatic logic [31:0] tbl(input logic [8:0] i);
    if (i == 9'd1) return 32'h0030_0882;
    return {8'hA5, 16'h3100 + 16'(i) * 16'h0011, 8'h40 + 8'(i)};
  endfunction

  assign rdata = tbl(idx);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected request stream; dly is clocks from the previous reference edge
  // (start sample or completion pulse) to the request rising.
  task automatic build(input int n);
    int          d, nk;
    logic [31:0] w;
    logic        stop;
    d = PW + 1;
    exp_err = 1'b0;
    exp_idx = n;
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) begin
      nk = nack_left[i] + both_left[i];
      w  = tbl(9'(i));
      for (int a = 0; a <= nk && a <= MAXR; a++) begin
        sb.push_back('{i, w[23:8], w[7:0], d});
        d = (a < nk) ? GAP : ((i == RSTI) ? DLY + 1 : GAP + 1);
      end
      if (nk > MAXR) begin
        exp_err = 1'b1;
        exp_idx = i;
        stop = 1'b1;
      end
    end
  endtask

  task automatic kick(input int n);
    @(negedge clk);
    size = 9'(n);
    build(n);
    start = 1'b1;
    ref_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(done || err), 1);
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_index"}, 32'(idx), exp_idx);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // I2C master model: completes each request 3 clocks after it rises.
  initial begin
    ack = 1'b0;
    nack = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      nack = 1'b0;
      if (!req) rsp_age = 0;
      else begin
        rsp_age++;
        if (rsp_age == 3) begin
          ref_cyc = cyc + 1;
          if (both_left[idx] > 0) begin
            both_left[idx]--;
            ack = 1'b1;
            nack = 1'b1;
          end else if (nack_left[idx] > 0) begin
            nack_left[idx]--;
            nack = 1'b1;
          end else ack = 1'b1;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req && !mon_prev) begin
        if (sb.size() == 0) chk("extra_req", 1, 0);
        else begin
          e = sb.pop_front();
          chk("req_idx", 32'(idx), e.idx);
          chk("req_addr", 32'(waddr), 32'(e.addr));
          chk("req_data", 32'(wdata), 32'(e.data));
          chk("req_spacing", cyc - ref_cyc, e.dly);
        end
      end
      mon_prev = req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    size = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_index", 32'(idx), 0);
    chk("rst_addr", 32'(waddr), 0);
    chk("rst_data", 32'(wdata), 0);
    rst = 1'b0;

    // Clean pass; a second start while busy must be ignored.
    kick(5);
    repeat (30) @(negedge clk);
    chk("t1_busy_mid", 32'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("t1");

    // Entry 2: one ack+nack collision, one nack, then ack.
    both_left[2] = 1;
    nack_left[2] = 1;
    kick(5);
    wait_end("t2");

    // Entry 3 exhausts its retries.
    nack_left[3] = 4;
    kick(5);
    wait_end("t3");
    repeat (20) @(negedge clk);
    chk("t3_quiet", 32'(req), 0);
    chk("t3_err_hold", 32'(err), 1);

    // Reset while requesting entry 2, then a fresh pass from index 0.
    kick(5);
    n = 0;
    while (!(req && idx == 9'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach", 32'(req && idx == 9'd2), 1);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("t4_req", 32'(req), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_err", 32'(err), 0);
    chk("t4_index", 32'(idx), 0);
    chk("t4_addr", 32'(waddr), 0);
    rst = 1'b0;
    kick(5);
    wait_end("t4b");

    // Empty table finishes after power-up with no writes.
    kick(0);
    wait_end("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
